// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, status bit layout and parity helper.
package ps2_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DEV_ACK = 1;
    localparam int unsigned STAT_ERR     = 2;

    // Bit counter value once start, d0..d7, parity and stop have been driven
    localparam logic [3:0] BIT_CNT_STOP = 4'd10;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pad plus falling-edge detect on the synced value.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines are high; resetting to 1 avoids a false edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter, Wishbone slave; open-drain enables only,
// the system top turns ps2_*_oe_o into pad drives (oe ? 1'b0 : 1'bz).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMER_100USEC_VALUE_PP = 1250,
    parameter int unsigned TIMER_100USEC_BITS_PP  = 11,
    parameter int unsigned TIMEOUT_VALUE_PP       = 25000,
    parameter int unsigned TIMEOUT_BITS_PP        = 15
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    output logic       wb_ack_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic       busy_o
);

    localparam logic [TIMER_100USEC_BITS_PP-1:0] TIMER_LAST =
        TIMER_100USEC_BITS_PP'(TIMER_100USEC_VALUE_PP - 1);
    localparam logic [TIMEOUT_BITS_PP-1:0] TMO_LAST =
        TIMEOUT_BITS_PP'(TIMEOUT_VALUE_PP - 1);

    logic clk_sync, clk_fall, dat_sync, dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_i),
        .din    (ps2_clk_i),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_i),
        .din    (ps2_dat_i),
        .sync_o (dat_sync),
        .fall_o (dat_fall_unused)
    );

    logic [2:0]                       state_q, state_d;
    logic [9:0]                       tx_q, tx_d;
    logic [3:0]                       bit_cnt_q, bit_cnt_d;
    logic [TIMER_100USEC_BITS_PP-1:0] timer_q, timer_d;
    logic [TIMEOUT_BITS_PP-1:0]       tmo_q, tmo_d;
    logic                             clk_oe_q, clk_oe_d;
    logic                             dat_oe_q, dat_oe_d;
    logic                             err_q, err_d;
    logic                             dev_ack_q, dev_ack_d;
    logic                             ack_q, ack_d;
    logic [7:0]                       dat_o_q, dat_o_d;
    logic                             busy, wr_acc;
    logic [7:0]                       status;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        tmo_d     = tmo_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        err_d     = err_q;
        dev_ack_d = dev_ack_q;
        dat_o_d   = dat_o_q;

        status               = '0;
        status[STAT_BUSY]    = busy;
        status[STAT_DEV_ACK] = dev_ack_q;
        status[STAT_ERR]     = err_q;

        ack_d  = wb_stb_i & ~ack_q;
        wr_acc = ack_d & wb_we_i;
        if (ack_d && !wb_we_i) dat_o_d = status;
        if (wr_acc && busy) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    tx_d      = {1'b1, odd_parity(wb_dat_i), wb_dat_i};
                    err_d     = 1'b0;
                    dev_ack_d = 1'b0;
                    timer_d   = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes low one cycle before the clock is released
                if (dat_oe_q) begin
                    clk_oe_d  = 1'b0;
                    tmo_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = REQ;
                end else if (timer_q == TIMER_LAST) begin
                    dat_oe_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REQ, DATA, ACK: begin
                if (clk_fall) begin
                    tmo_d = '0;
                    if (state_q == ACK) begin
                        if (dat_sync) err_d = 1'b1;
                        else          dev_ack_d = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        dat_oe_d  = ~tx_q[0];
                        tx_d      = {1'b1, tx_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = (bit_cnt_d == BIT_CNT_STOP) ? ACK : DATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && dat_sync) state_d = IDLE;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            tmo_q     <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            err_q     <= 1'b0;
            dev_ack_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_o_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            tmo_q     <= tmo_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            err_q     <= err_d;
            dev_ack_q <= dev_ack_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
        end
    end

    assign wb_dat_o     = dat_o_q;
    assign wb_ack_o     = ack_q;
    assign ps2_clk_oe_o = clk_oe_q;
    assign ps2_dat_oe_o = dat_oe_q;
    assign busy_o       = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: Wishbone master, open-drain line model and a keyboard-side BFM
// that samples each transmitted bit against a scoreboard filled when the command is written.
module tb_ps2_host_tx;

    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_ack;
    logic       clk_oe, dat_oe, busy;
    logic       dev_clk_low, dev_dat_low;
    logic       clk_line, dat_line;

    int n_cmp = 0;
    int n_bad = 0;

    logic       sb_bits[$];
    logic [7:0] sb_stat[$];

    always #40 clk = ~clk;

    assign clk_line = ~(clk_oe | dev_clk_low);
    assign dat_line = ~(dat_oe | dev_dat_low);

    ps2_host_tx #(
        .TIMER_100USEC_VALUE_PP (1250),
        .TIMER_100USEC_BITS_PP  (11),
        .TIMEOUT_VALUE_PP       (25000),
        .TIMEOUT_BITS_PP        (15)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_we_i      (wb_we),
        .wb_stb_i     (wb_stb),
        .wb_ack_o     (wb_ack),
        .ps2_clk_i    (clk_line),
        .ps2_dat_i    (dat_line),
        .ps2_clk_oe_o (clk_oe),
        .ps2_dat_oe_o (dat_oe),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sb_bits.push_back(b[i]);
        sb_bits.push_back(~^b);
        sb_bits.push_back(1'b1);
    endtask

    task automatic wb_cycle(input logic we, input logic [7:0] d, output logic [7:0] rd);
        step();
        wb_stb = 1'b1; wb_we = we; wb_dat_i = d;
        step();
        wb_stb = 1'b0;
        check("ack_rise", {31'd0, wb_ack}, 32'd1);
        rd = wb_dat_o;
        step();
        check("ack_single", {31'd0, wb_ack}, 32'd0);
    endtask

    task automatic wb_write(input logic [7:0] d);
        logic [7:0] rd;
        wb_cycle(1'b1, d, rd);
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        logic [7:0] rd;
        sb_stat.push_back(exp);
        wb_cycle(1'b0, 8'h00, rd);
        check(tag, {24'd0, rd}, {24'd0, sb_stat.pop_front()});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20000) begin
            step();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Keyboard side: watch the request, then clock out npulse bits (11 includes the ack slot)
    task automatic dev_xfer(input int npulse, input bit do_ack);
        int n = 0;
        logic exp;
        while (clk_line && n < 5000) begin
            step();
            n++;
        end
        check("inhibit_seen", {31'd0, clk_line}, 32'd0);
        n = 0;
        while (!clk_line && n < 5000) begin
            step();
            n++;
        end
        check("inhibit_len", {31'd0, (n >= 1250 && n < 1300)}, 32'd1);
        check("start_bit", {31'd0, dat_line}, 32'd0);
        repeat (20) step();
        for (int k = 1; k <= npulse && k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) step();
            if (sb_bits.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp = sb_bits.pop_front();
                check($sformatf("bit%0d", k), {31'd0, dat_line}, {31'd0, exp});
            end
            dev_clk_low = 1'b0;
            repeat (HALF) step();
        end
        if (npulse >= 11) begin
            if (do_ack) dev_dat_low = 1'b1;
            repeat (20) step();
            dev_clk_low = 1'b1;
            repeat (HALF) step();
            dev_clk_low = 1'b0;
            repeat (HALF) step();
            dev_dat_low = 1'b0;
        end
    endtask

    initial begin
        #(80 * 200000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] rd;
        rst_n = 1'b0;
        wb_stb = 1'b0; wb_we = 1'b0; wb_dat_i = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        #1;
        check("rst_outputs", {20'd0, wb_dat_o, wb_ack, clk_oe, dat_oe, busy}, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Idle status read and back-to-back strobes
        read_status("idle_status", 8'h00);
        wb_stb = 1'b1; wb_we = 1'b0;
        step(); check("b2b_ack0", {31'd0, wb_ack}, 32'd1);
        step(); check("b2b_ack1", {31'd0, wb_ack}, 32'd0);
        step(); check("b2b_ack2", {31'd0, wb_ack}, 32'd1);
        step(); check("b2b_ack3", {31'd0, wb_ack}, 32'd0);
        wb_stb = 1'b0;
        step();

        // 0xED with device ack
        push_byte(8'hED);
        wb_write(8'hED);
        dev_xfer(11, 1'b1);
        wait_idle("ed_idle");
        read_status("ed_status", 8'h02);

        // 0xFF, ack withheld
        push_byte(8'hFF);
        wb_write(8'hFF);
        dev_xfer(11, 1'b0);
        wait_idle("ff_idle");
        read_status("ff_status", 8'h04);

        // Device never clocks: timeout
        wb_write(8'hF3);
        n = 0;
        while (!(dat_oe && !clk_oe) && n < 3000) begin
            step();
            n++;
        end
        check("tmo_req", {30'd0, clk_oe, dat_oe}, 32'd1);
        n = 0;
        while (busy && n < 30000) begin
            step();
            n++;
        end
        check("tmo_len", {31'd0, (n >= 24990 && n <= 25010)}, 32'd1);
        check("tmo_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
        read_status("tmo_status", 8'h04);

        // Write while busy is rejected but acked; transfer completes
        push_byte(8'h00);
        wb_write(8'h00);
        fork
            dev_xfer(11, 1'b1);
            begin
                n = 0;
                while (!(busy && !clk_oe) && n < 3000) begin
                    step();
                    n++;
                end
                repeat (6 * HALF) step();
                wb_write(8'h55);
            end
        join
        wait_idle("rej_idle");
        read_status("rej_status", 8'h06);

        // Reset in the middle of a byte
        push_byte(8'hA5);
        wb_write(8'hA5);
        dev_xfer(5, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {20'd0, wb_dat_o, wb_ack, clk_oe, dat_oe, busy}, 32'd0);
        sb_bits.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        push_byte(8'hF4);
        wb_write(8'hF4);
        dev_xfer(11, 1'b1);
        wait_idle("f4_idle");
        read_status("f4_status", 8'h02);
        check("sb_drained", sb_bits.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
